// File: rtl/adc_valid_monitor_pkg.sv
// Shared types, field widths and status-word layout for the ADC valid monitor.
package adc_valid_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam int unsigned VALID_CNT_W = 17;
  localparam int unsigned GAP_CNT_W   = 12;
  localparam int unsigned GOOD_RUN_W  = 4;
  localparam int unsigned COUNT_W     = 16;
  localparam int unsigned STATUS_W    = 32;

  localparam int unsigned ST_LOCKED_BIT = 31;
  localparam int unsigned ST_STICKY_BIT = 30;
  localparam int unsigned ST_STATE_LSB  = 28;
  localparam int unsigned ST_MAXGAP_LSB = 16;
  localparam int unsigned ST_COUNT_LSB  = 0;

  // Window totals above 0xFFFF (only possible with a 2^16 window) clamp to 0xFFFF.
  function automatic logic [COUNT_W-1:0] sat_count(input logic [VALID_CNT_W-1:0] total);
    return total[VALID_CNT_W-1] ? '1 : total[COUNT_W-1:0];
  endfunction

  function automatic logic [STATUS_W-1:0] pack_status(
    input logic                 lk,
    input logic                 sticky,
    input state_t               st,
    input logic [GAP_CNT_W-1:0] gap,
    input logic [COUNT_W-1:0]   count
  );
    logic [STATUS_W-1:0] w;
    w = '0;
    w[ST_LOCKED_BIT]                = lk;
    w[ST_STICKY_BIT]                = sticky;
    w[ST_STATE_LSB +: 2]            = st;
    w[ST_MAXGAP_LSB +: GAP_CNT_W]   = gap;
    w[ST_COUNT_LSB +: COUNT_W]      = count;
    return w;
  endfunction

endpackage

// File: rtl/adc_valid_monitor_if.sv
// Strobe/control inputs and status outputs of the ADC valid monitor.
interface adc_valid_monitor_if;
  import adc_valid_monitor_pkg::*;

  logic                adc_valid;
  logic                ctrl_clear;
  logic [STATUS_W-1:0] status_word;
  logic                locked;

  modport master (output adc_valid, output ctrl_clear, input status_word, input locked);
  modport slave  (input adc_valid, input ctrl_clear, output status_word, output locked);
endinterface

// File: rtl/adc_valid_gap_tracker.sv
// Tracks runs of invalid ADC cycles and the longest run since reset/clear.
module adc_valid_gap_tracker
  import adc_valid_monitor_pkg::*;
#(
  parameter int unsigned MAX_GAP = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adc_valid,
  input  logic                 clear,
  output logic                 gap_over,
  output logic [GAP_CNT_W-1:0] max_gap
);

  logic [GAP_CNT_W-1:0] gap_q;
  logic [GAP_CNT_W-1:0] gap_d;

  // Next gap value: zero on a valid cycle, otherwise count up and hold at all ones.
  always_comb begin
    gap_d = '0;
    if (!adc_valid) begin
      gap_d = (&gap_q) ? gap_q : gap_q + GAP_CNT_W'(1);
    end
  end

  // Flagged in the same cycle the run first exceeds the tolerated length.
  assign gap_over = 32'(gap_d) > MAX_GAP;

  // Gap register and running maximum; a clear restarts the maximum from the live gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q   <= '0;
      max_gap <= '0;
    end else begin
      gap_q <= gap_d;
      if (clear || (gap_d > max_gap)) begin
        max_gap <= gap_d;
      end
    end
  end

endmodule

// File: rtl/adc_valid_monitor.sv
// Measures ADC sample-valid density per window, tracks lock, and publishes a status word.
module adc_valid_monitor
  import adc_valid_monitor_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2  = 16,
  parameter int unsigned VALID_THRESH = 65280,
  parameter int unsigned LOCK_WINDOWS = 4,
  parameter int unsigned MAX_GAP      = 8
) (
  input logic                user_clk,
  input logic                user_rst,
  adc_valid_monitor_if.slave bus
);

  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [VALID_CNT_W-1:0] valid_cnt;
  logic [VALID_CNT_W-1:0] window_total;
  logic                   window_end;
  logic                   window_good;
  logic                   clear_q;
  logic                   clear_pulse;
  state_t                 state_q;
  state_t                 state_d;
  logic [GOOD_RUN_W-1:0]  good_run_q;
  logic [GOOD_RUN_W-1:0]  good_run_d;
  logic [GOOD_RUN_W-1:0]  run_inc;
  logic                   enter_lost;
  logic                   sticky_lost;
  logic                   gap_over;
  logic [GAP_CNT_W-1:0]   max_gap;
  logic [STATUS_W-1:0]    status_q;

  assign window_end   = &win_cnt;
  assign window_total = valid_cnt + VALID_CNT_W'(bus.adc_valid);
  assign window_good  = 32'(window_total) >= VALID_THRESH;
  assign clear_pulse  = bus.ctrl_clear & ~clear_q;
  assign run_inc      = good_run_q + GOOD_RUN_W'(1);

  // Free-running window counter and per-window valid accumulator.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      win_cnt   <= '0;
      valid_cnt <= '0;
    end else begin
      win_cnt   <= win_cnt + WINDOW_LOG2'(1);
      valid_cnt <= window_end ? '0 : window_total;
    end
  end

  // Single-register edge detector on the software clear level.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      clear_q <= 1'b0;
    end else begin
      clear_q <= bus.ctrl_clear;
    end
  end

  adc_valid_gap_tracker #(
    .MAX_GAP (MAX_GAP)
  ) u_gap (
    .clk       (user_clk),
    .rst       (user_rst),
    .adc_valid (bus.adc_valid),
    .clear     (clear_pulse),
    .gap_over  (gap_over),
    .max_gap   (max_gap)
  );

  // Lock FSM next-state: windows are judged only at their end cycle.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    enter_lost = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.adc_valid) begin
          state_d    = ACQUIRE;
          good_run_d = '0;
        end
      end
      ACQUIRE: begin
        if (window_end) begin
          if (window_good) begin
            good_run_d = run_inc;
            if (32'(run_inc) >= LOCK_WINDOWS) begin
              state_d = LOCKED;
            end
          end else begin
            good_run_d = '0;
          end
        end
      end
      LOCKED: begin
        if ((window_end && !window_good) || gap_over) begin
          state_d    = LOST;
          enter_lost = 1'b1;
        end
      end
      LOST: begin
        if (window_end && window_good) begin
          state_d    = ACQUIRE;
          good_run_d = GOOD_RUN_W'(1);
        end
      end
    endcase
  end

  // Lock FSM state and good-window run register.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q    <= IDLE;
      good_run_q <= '0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
    end
  end

  // Sticky loss flag; a new loss takes priority over a coincident clear.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      sticky_lost <= 1'b0;
    end else if (enter_lost) begin
      sticky_lost <= 1'b1;
    end else if (clear_pulse) begin
      sticky_lost <= 1'b0;
    end
  end

  // Status word: count field refreshes at window end, other fields follow their sources.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      status_q <= '0;
    end else begin
      status_q <= pack_status(state_q == LOCKED, sticky_lost, state_q, max_gap,
                              window_end ? sat_count(window_total)
                                         : status_q[ST_COUNT_LSB +: COUNT_W]);
    end
  end

  assign bus.status_word = status_q;
  assign bus.locked      = status_q[ST_LOCKED_BIT];

endmodule

// File: tb/tb_adc_valid_monitor.sv
// Directed bench for adc_valid_monitor with a 16-cycle window, threshold 14, 2-window lock, gap limit 3.
module tb_adc_valid_monitor;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned t;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit          drop [0:255];

  adc_valid_monitor_if bus ();

  adc_valid_monitor #(
    .WINDOW_LOG2  (4),
    .VALID_THRESH (14),
    .LOCK_WINDOWS (2),
    .MAX_GAP      (3)
  ) dut (
    .user_clk (clk),
    .user_rst (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%08h exp=%08h", tag, t, got, exp);
    end
  endtask

  // One clock: inputs applied now, outputs observed at the following negedge.
  task automatic tick(input logic v);
    bus.adc_valid = v;
    @(negedge clk);
    t++;
  endtask

  task automatic run_until(input int unsigned last);
    while (t < last) tick(!drop[t + 1]);
  endtask

  initial begin
    rst            = 1'b1;
    bus.adc_valid  = 1'b0;
    bus.ctrl_clear = 1'b0;
    t              = 0;
    drop           = '{default: 1'b0};
    @(negedge clk);
    tick(1'b0);
    check_eq("reset_status", bus.status_word, 32'h0000_0000);
    check_eq("reset_locked", 32'(bus.locked), 32'd0);

    // Idle with no valid samples: only max_gap moves, one cycle behind the gap.
    rst = 1'b0;
    t   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0);
      check_eq("idle_gap", bus.status_word, 32'(i - 1) << 16);
    end
    while (t < 4100) tick(1'b0);
    check_eq("gap_saturate", bus.status_word, 32'h0FFF_0000);
    bus.ctrl_clear = 1'b1;
    tick(1'b0);
    tick(1'b0);
    check_eq("clear_loads_sat_gap", bus.status_word, 32'h0FFF_0000);
    bus.ctrl_clear = 1'b0;

    rst = 1'b1;
    tick(1'b1);
    check_eq("reset2_status", bus.status_word, 32'h0000_0000);
    rst = 1'b0;
    t   = 0;
    drop = '{default: 1'b0};
    drop[35] = 1'b1; drop[36] = 1'b1; drop[37] = 1'b1; drop[38] = 1'b1;
    drop[83] = 1'b1; drop[86] = 1'b1;
    drop[99] = 1'b1; drop[102] = 1'b1; drop[105] = 1'b1;
    drop[115] = 1'b1; drop[116] = 1'b1;

    // Acquire and lock on continuous valid.
    run_until(1);   check_eq("acq_t1",  bus.status_word, 32'h0000_0000);
    run_until(2);   check_eq("acq_t2",  bus.status_word, 32'h1000_0000);
    run_until(16);  check_eq("win1",    bus.status_word, 32'h1000_0010);
    run_until(32);  check_eq("win2",    bus.status_word, 32'h1000_0010);
    check_eq("win2_locked", 32'(bus.locked), 32'd0);
    run_until(33);  check_eq("lock",    bus.status_word, 32'hA000_0010);
    check_eq("lock_locked", 32'(bus.locked), 32'd1);

    // Four-cycle gap while locked.
    run_until(38);  check_eq("gap_pre_lost", bus.status_word, 32'hA003_0010);
    run_until(39);  check_eq("gap_lost",     bus.status_word, 32'h7004_0010);
    check_eq("gap_lost_locked", 32'(bus.locked), 32'd0);
    run_until(49);  check_eq("lost_badwin",  bus.status_word, 32'h7004_000C);
    run_until(65);  check_eq("reacquire",    bus.status_word, 32'h5004_0010);
    run_until(81);  check_eq("relock",       bus.status_word, 32'hE004_0010);
    check_eq("relock_locked", 32'(bus.locked), 32'd1);

    // Clear while locked, then count-14 and count-13 windows.
    bus.ctrl_clear = 1'b1;
    run_until(83);  check_eq("clear_locked", bus.status_word, 32'hA000_0010);
    run_until(84);
    bus.ctrl_clear = 1'b0;
    run_until(97);  check_eq("cnt14_stays", bus.status_word, 32'hA001_000E);
    check_eq("cnt14_locked", 32'(bus.locked), 32'd1);
    run_until(111);
    bus.ctrl_clear = 1'b1;
    run_until(113); check_eq("cnt13_lost_setwins", bus.status_word, 32'h7000_000D);
    check_eq("cnt13_locked", 32'(bus.locked), 32'd0);
    bus.ctrl_clear = 1'b0;
    run_until(119); check_eq("lost_gap2", bus.status_word, 32'h7002_000D);
    bus.ctrl_clear = 1'b1;
    run_until(121); check_eq("clear_in_lost", bus.status_word, 32'h3000_000D);
    bus.ctrl_clear = 1'b0;
    run_until(129); check_eq("acq_after_clear", bus.status_word, 32'h1000_000E);
    run_until(145); check_eq("lock_again", bus.status_word, 32'hA000_0010);

    // Mid-window reset while locked.
    run_until(149);
    rst = 1'b1;
    tick(1'b1);
    check_eq("midreset_status", bus.status_word, 32'h0000_0000);
    check_eq("midreset_locked", 32'(bus.locked), 32'd0);
    rst  = 1'b0;
    t    = 0;
    drop = '{default: 1'b0};
    drop[3] = 1'b1; drop[4] = 1'b1;
    run_until(1);   check_eq("post_t1",  bus.status_word, 32'h0000_0000);
    run_until(2);   check_eq("post_t2",  bus.status_word, 32'h1000_0000);
    run_until(15);  check_eq("post_t15", bus.status_word, 32'h1002_0000);
    run_until(16);  check_eq("post_win", bus.status_word, 32'h1002_000E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
